// File: rtl/spi_pkg.sv
// Shared constants, state type and bit-ordering helper for the SPI target.
package spi_pkg;

    localparam int WORD_SLOW = 8;
    localparam int WORD_FAST = 32;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spiState_t;

    // Maps the running bit count to a word bit position: bytes go out
    // lowest first, and each byte goes out MSB first.
    function automatic logic [4:0] bitIndex(input logic [4:0] count);
        return {count[4:3], ~count[2:0]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one SPI pin, with rise/fall detection on the
// synchronised level. RESET_VAL should match the pin's idle level so that
// leaving reset does not look like an edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Shift the raw pin through the synchroniser and keep the previous sample for edge compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, fully oversampled in the clk domain. Receives 8- or
// 32-bit words, presents them with a one-cycle valid pulse, and transmits
// from a one-entry holding register (FILL pattern when it runs dry).
module spi_target
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL        = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        fast,
    input  logic [31:0] tx_data,
    input  logic        tx_load,
    output logic        tx_full,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        underrun,
    output logic        abort,
    input  logic        clr_err
);

    localparam logic [4:0] LAST_SLOW = 5'(WORD_SLOW - 1);
    localparam logic [4:0] LAST_FAST = 5'(WORD_FAST - 1);

    logic sclkRise, sclkFall, ssRise, ssFall;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic mosiSample;

    spiState_t   state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        wordFast_q, wordFast_d;
    logic [31:0] activeWord_q, activeWord_d;
    logic [31:0] rxShift_q, rxShift_d;
    logic [31:0] rxData_q, rxData_d;
    logic        rxValid_q, rxValid_d;
    logic [31:0] txHold_q, txHold_d;
    logic        txFull_q, txFull_d;
    logic        underrun_q, underrun_d;
    logic        abort_q, abort_d;
    logic        miso_q, miso_d;
    logic        startWord;
    logic [4:0]  lastCount;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sclkSync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sclk),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) ssSync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (ss_n),
        .rise_o (ssRise),
        .fall_o (ssFall)
    );

    // Data pin only needs to be synchronised; it is sampled on synchronised sclk rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosiSync_q <= '0;
        end else begin
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosiSample = mosiSync_q[SYNC_STAGES-1];
    assign lastCount  = wordFast_q ? LAST_FAST : LAST_SLOW;

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wordFast_q   <= 1'b0;
            activeWord_q <= '0;
            rxShift_q    <= '0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            txHold_q     <= '0;
            txFull_q     <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
            miso_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wordFast_q   <= wordFast_d;
            activeWord_q <= activeWord_d;
            rxShift_q    <= rxShift_d;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            txHold_q     <= txHold_d;
            txFull_q     <= txFull_d;
            underrun_q   <= underrun_d;
            abort_q      <= abort_d;
            miso_q       <= miso_d;
        end
    end

    // Next-state logic: ss_n edges take priority over sclk edges; word start
    // is applied after the FSM so it overrides, and tx_load is applied last so
    // a same-cycle load survives the transfer out of the holding register.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wordFast_d   = wordFast_q;
        activeWord_d = activeWord_q;
        rxShift_d    = rxShift_q;
        rxData_d     = rxData_q;
        rxValid_d    = 1'b0;
        txHold_d     = txHold_q;
        txFull_d     = txFull_q;
        underrun_d   = underrun_q;
        abort_d      = 1'b0;
        miso_d       = miso_q;
        startWord    = 1'b0;

        if (clr_err) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b1;
                if (ssFall) begin
                    state_d   = ACTIVE;
                    startWord = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssRise) begin
                    state_d = IDLE;
                    miso_d  = 1'b1;
                    count_d = '0;
                    if (count_q != 5'd0) begin
                        abort_d = 1'b1;
                    end
                end else if (sclkRise) begin
                    rxShift_d[bitIndex(count_q)] = mosiSample;
                    if (count_q == lastCount) begin
                        rxData_d  = wordFast_q ? rxShift_d : {24'b0, rxShift_d[7:0]};
                        rxValid_d = 1'b1;
                        startWord = 1'b1;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end else if (sclkFall) begin
                    miso_d = activeWord_q[bitIndex(count_q)];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (startWord) begin
            wordFast_d = fast;
            count_d    = '0;
            if (txFull_q) begin
                activeWord_d = txHold_q;
                txFull_d     = 1'b0;
            end else begin
                activeWord_d = {4{FILL}};
                underrun_d   = 1'b1;
            end
            miso_d = activeWord_d[bitIndex(5'd0)];
        end

        if (tx_load) begin
            txHold_d = tx_data;
            txFull_d = 1'b1;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == ACTIVE);
    assign tx_full  = txFull_q;
    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign underrun = underrun_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: acts as a mode-0 SPI controller and checks
// received words, transmitted bits, flags and pulse counts against
// hand-computed values.
module tb_spi_target;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic        fast = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic        tx_full;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        underrun;
    logic        abort;
    logic        clr_err = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCnt = 0;
    int lastRiseCycle = 0;
    int lastRxCycle = 0;
    int abortCount = 0;
    logic [31:0] rxQ[$];
    logic        urQ[$];
    logic [63:0] misoBits;
    logic [31:0] wireSeq;

    spi_target #(.SYNC_STAGES(2), .FILL(8'hFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .fast     (fast),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_full  (tx_full),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .abort    (abort),
        .clr_err  (clr_err)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure response latency.
    always @(posedge clk) cycleCnt++;

    // Record every rx_valid pulse (with the underrun flag at that moment) and every abort pulse.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxQ.push_back(rx_data);
            urQ.push_back(underrun);
            lastRxCycle = cycleCnt;
        end
        if (abort) abortCount++;
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wire position c of a word: byte c/8, MSB of each byte first.
    function automatic int wireIdx(input int c);
        return (c / 8) * 8 + 7 - (c % 8);
    endfunction

    task automatic loadTx(input logic [31:0] value);
        tx_data = value;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic clearErr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    // Controller frame: nBits clocks under one ss_n low; mosiBits holds up
    // to two words ([31:0] first). Optional tx_load during bit loadAtBit.
    task automatic applyStimulus(input logic isFast, input int nBits, input logic [63:0] mosiBits,
                                 input int loadAtBit, input logic [31:0] loadVal, input logic deselect,
                                 output logic [63:0] rxBits, output logic [31:0] seq);
        int wordLen, w, c;
        wordLen = isFast ? 32 : 8;
        rxBits = '0;
        seq = '0;
        fast = isFast;
        sclk = 1'b0;
        ss_n = 1'b0;
        for (int b = 0; b < nBits; b++) begin
            w = b / wordLen;
            c = b % wordLen;
            sclk = 1'b0;
            mosi = mosiBits[w * 32 + wireIdx(c)];
            if (b == loadAtBit) begin
                tick(1);
                tx_data = loadVal;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(HALF - 2);
            end else begin
                tick(HALF);
            end
            rxBits[w * 32 + wireIdx(c)] = miso;
            if (b < 32) seq = {seq[30:0], miso};
            sclk = 1'b1;
            lastRiseCycle = cycleCnt;
            tick(HALF);
        end
        sclk = 1'b0;
        tick(HALF);
        if (deselect) begin
            ss_n = 1'b1;
            tick(HALF);
        end
    endtask

    initial begin
        tick(4);
        rst = 1'b0;
        tick(2);

        // Reset values
        checkOutput("rst_miso", 32'(miso), 32'd1);
        checkOutput("rst_miso_oe", 32'(miso_oe), 32'd0);
        checkOutput("rst_tx_full", 32'(tx_full), 32'd0);
        checkOutput("rst_rx_data", rx_data, 32'h0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_abort", 32'(abort), 32'd0);

        // Slow byte: target sends A5, controller sends 3C
        loadTx(32'h0000_00A5);
        checkOutput("t1_tx_full_set", 32'(tx_full), 32'd1);
        rxQ.delete(); urQ.delete();
        applyStimulus(1'b0, 8, {32'h0, 32'h0000_003C}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t1_rx_count", 32'(rxQ.size()), 32'd1);
        checkOutput("t1_rx_data", rx_data, 32'h0000_003C);
        checkOutput("t1_miso_byte", {24'h0, misoBits[7:0]}, 32'h0000_00A5);
        checkOutput("t1_tx_full_clr", 32'(tx_full), 32'd0);
        checkOutput("t1_latency", 32'(lastRxCycle - lastRiseCycle), 32'd3);
        checkOutput("t1_no_abort", 32'(abortCount), 32'd0);

        // Fast word: target sends 12345678, controller sends DEADBEEF
        clearErr();
        loadTx(32'h1234_5678);
        rxQ.delete(); urQ.delete();
        applyStimulus(1'b1, 32, {32'h0, 32'hDEAD_BEEF}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t2_rx_count", 32'(rxQ.size()), 32'd1);
        checkOutput("t2_rx_data", rx_data, 32'hDEAD_BEEF);
        checkOutput("t2_miso_word", misoBits[31:0], 32'h1234_5678);
        checkOutput("t2_wire_order", wireSeq, 32'h7856_3412);

        // Two back-to-back fast words, second load during word 1
        clearErr();
        loadTx(32'h1122_3344);
        rxQ.delete(); urQ.delete();
        applyStimulus(1'b1, 64, {32'hCAFE_F00D, 32'h0123_4567}, 10, 32'hA1B2_C3D4, 1'b1, misoBits, wireSeq);
        checkOutput("t3_rx_count", 32'(rxQ.size()), 32'd2);
        checkOutput("t3_rx_word0", rxQ[0], 32'h0123_4567);
        checkOutput("t3_rx_word1", rxQ[1], 32'hCAFE_F00D);
        checkOutput("t3_miso_word0", misoBits[31:0], 32'h1122_3344);
        checkOutput("t3_miso_word1", misoBits[63:32], 32'hA1B2_C3D4);
        checkOutput("t3_no_underrun_w2", 32'(urQ[0]), 32'd0);
        checkOutput("t3_underrun_after_last", 32'(urQ[1]), 32'd1);
        checkOutput("t3_tx_full", 32'(tx_full), 32'd0);

        // Empty holding register: FILL streams out and underrun sets
        clearErr();
        checkOutput("t4_underrun_cleared", 32'(underrun), 32'd0);
        rxQ.delete(); urQ.delete();
        applyStimulus(1'b0, 8, {32'h0, 32'h0000_005A}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t4_miso_fill", {24'h0, misoBits[7:0]}, 32'h0000_00FF);
        checkOutput("t4_underrun_set", 32'(underrun), 32'd1);
        checkOutput("t4_rx_data", rx_data, 32'h0000_005A);
        clearErr();
        checkOutput("t4_clr_err", 32'(underrun), 32'd0);

        // Abort after 5 bits, then a clean frame
        loadTx(32'h0000_0096);
        rxQ.delete(); urQ.delete();
        abortCount = 0;
        applyStimulus(1'b0, 5, {32'h0, 32'h0000_00E7}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t5_abort_count", 32'(abortCount), 32'd1);
        checkOutput("t5_no_rx_valid", 32'(rxQ.size()), 32'd0);
        checkOutput("t5_tx_full", 32'(tx_full), 32'd0);
        checkOutput("t5_rx_data_kept", rx_data, 32'h0000_005A);
        loadTx(32'h0000_003A);
        applyStimulus(1'b0, 8, {32'h0, 32'h0000_00C3}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t5_next_rx", rx_data, 32'h0000_00C3);
        checkOutput("t5_next_miso", {24'h0, misoBits[7:0]}, 32'h0000_003A);
        checkOutput("t5_abort_once", 32'(abortCount), 32'd1);

        // Reset at bit 3 of a fast word, then a clean fast frame
        loadTx(32'hFEED_FACE);
        applyStimulus(1'b1, 3, {32'h0, 32'hFFFF_FFFF}, -1, 32'h0, 1'b0, misoBits, wireSeq);
        checkOutput("t6_selected_oe", 32'(miso_oe), 32'd1);
        loadTx(32'h0000_0077);
        rst = 1'b1;
        tick(1);
        checkOutput("t6_rst_miso", 32'(miso), 32'd1);
        checkOutput("t6_rst_miso_oe", 32'(miso_oe), 32'd0);
        checkOutput("t6_rst_tx_full", 32'(tx_full), 32'd0);
        checkOutput("t6_rst_rx_data", rx_data, 32'h0);
        checkOutput("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        ss_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        loadTx(32'h89AB_CDEF);
        rxQ.delete(); urQ.delete();
        applyStimulus(1'b1, 32, {32'h0, 32'h55AA_33CC}, -1, 32'h0, 1'b1, misoBits, wireSeq);
        checkOutput("t6_after_rx", rx_data, 32'h55AA_33CC);
        checkOutput("t6_after_miso", misoBits[31:0], 32'h89AB_CDEF);
        checkOutput("t6_after_count", 32'(rxQ.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
